// File: rtl/mem_access_stage_if.sv
// Bundle of the MEM stage's EX/MEM-side inputs, data-memory port and WB-side outputs.
// The slave view belongs to the stage; the master view belongs to whatever surrounds it.
interface mem_access_stage_if;
  logic        in_valid;
  logic        in_ready;
  logic        flush;
  logic        MemRead;
  logic        MemWrite;
  logic [1:0]  mem_size;
  logic        mem_unsigned;
  logic        RegWrite;
  logic [4:0]  rd;
  logic [1:0]  DatatoReg;
  logic [31:0] pc_4;
  logic [31:0] lui_32;
  logic [31:0] ALU_result;
  logic [31:0] store_data;

  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [3:0]  dmem_be;
  logic [31:0] dmem_wdata;
  logic        dmem_ack;
  logic [31:0] dmem_rdata;

  logic        wb_valid;
  logic        wb_RegWrite;
  logic [4:0]  wb_rd;
  logic [1:0]  wb_DatatoReg;
  logic [31:0] wb_pc_4;
  logic [31:0] wb_lui_32;
  logic [31:0] wb_mem_data_out;
  logic [31:0] wb_ALU_result;
  logic        addr_err;
  logic        bus_err;

  modport slave (
    input  in_valid, flush, MemRead, MemWrite, mem_size, mem_unsigned, RegWrite, rd,
           DatatoReg, pc_4, lui_32, ALU_result, store_data, dmem_ack, dmem_rdata,
    output in_ready, dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
           wb_valid, wb_RegWrite, wb_rd, wb_DatatoReg, wb_pc_4, wb_lui_32,
           wb_mem_data_out, wb_ALU_result, addr_err, bus_err
  );

  modport master (
    output in_valid, flush, MemRead, MemWrite, mem_size, mem_unsigned, RegWrite, rd,
           DatatoReg, pc_4, lui_32, ALU_result, store_data, dmem_ack, dmem_rdata,
    input  in_ready, dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
           wb_valid, wb_RegWrite, wb_rd, wb_DatatoReg, wb_pc_4, wb_lui_32,
           wb_mem_data_out, wb_ALU_result, addr_err, bus_err
  );
endinterface

// File: rtl/mem_access_stage.sv
// MEM stage with MEM/WB register: one instruction per handshake, req/ack data-memory
// access with lane alignment, misalignment trap and access timeout.
module mem_access_stage #(
  parameter int unsigned TIMEOUT = 16,
  parameter int unsigned CNT_W   = 5
) (
  input  logic              clk,
  input  logic              reset,
  mem_access_stage_if.slave bus
);

  typedef enum logic {IDLE, BUSY} state_e;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             flush_q, flush_d;

  logic        re_q, re_d;
  logic        we_q, we_d;
  logic        uns_q, uns_d;
  logic        rw_q, rw_d;
  logic [1:0]  size_q, size_d;
  logic [1:0]  dtr_q, dtr_d;
  logic [4:0]  rd_q, rd_d;
  logic [31:0] pc4_q, pc4_d;
  logic [31:0] lui_q, lui_d;
  logic [31:0] alu_q, alu_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  be_q, be_d;

  logic        wb_valid_q, wb_valid_d;
  logic        wb_rw_q, wb_rw_d;
  logic [4:0]  wb_rd_q, wb_rd_d;
  logic [1:0]  wb_dtr_q, wb_dtr_d;
  logic [31:0] wb_pc4_q, wb_pc4_d;
  logic [31:0] wb_lui_q, wb_lui_d;
  logic [31:0] wb_mem_q, wb_mem_d;
  logic [31:0] wb_alu_q, wb_alu_d;
  logic        addr_err_q, addr_err_d;
  logic        bus_err_q, bus_err_d;

  logic        is_mem;
  logic        misaligned;
  logic [3:0]  in_be;
  logic [31:0] in_wdata;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic [31:0] load_data;
  logic        squash;
  logic        busy;

  // Lane decode of the incoming instruction, captured at accept.
  always_comb begin
    is_mem     = bus.MemRead | bus.MemWrite;
    misaligned = 1'b0;
    in_be      = 4'b1111;
    in_wdata   = bus.store_data;
    case (bus.mem_size)
      2'b00: begin
        in_be    = 4'b0001 << bus.ALU_result[1:0];
        in_wdata = {4{bus.store_data[7:0]}};
      end
      2'b01: begin
        misaligned = bus.ALU_result[0];
        in_be      = bus.ALU_result[1] ? 4'b1100 : 4'b0011;
        in_wdata   = {2{bus.store_data[15:0]}};
      end
      default: misaligned = |bus.ALU_result[1:0];
    endcase
    if (!bus.MemWrite) in_wdata = '0;
  end

  // Load lane extraction uses the captured address/size, read data arrives with ack.
  always_comb begin
    byte_sel  = 8'(bus.dmem_rdata >> {alu_q[1:0], 3'b000});
    half_sel  = 16'(bus.dmem_rdata >> {alu_q[1], 4'b0000});
    load_data = bus.dmem_rdata;
    case (size_q)
      2'b00:   load_data = uns_q ? {24'b0, byte_sel} : {{24{byte_sel[7]}}, byte_sel};
      2'b01:   load_data = uns_q ? {16'b0, half_sel} : {{16{half_sel[15]}}, half_sel};
      default: load_data = bus.dmem_rdata;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    flush_d    = flush_q;
    re_d       = re_q;
    we_d       = we_q;
    uns_d      = uns_q;
    rw_d       = rw_q;
    size_d     = size_q;
    dtr_d      = dtr_q;
    rd_d       = rd_q;
    pc4_d      = pc4_q;
    lui_d      = lui_q;
    alu_d      = alu_q;
    wdata_d    = wdata_q;
    be_d       = be_q;
    wb_valid_d = 1'b0;
    addr_err_d = 1'b0;
    bus_err_d  = 1'b0;
    wb_rw_d    = wb_rw_q;
    wb_rd_d    = wb_rd_q;
    wb_dtr_d   = wb_dtr_q;
    wb_pc4_d   = wb_pc4_q;
    wb_lui_d   = wb_lui_q;
    wb_mem_d   = wb_mem_q;
    wb_alu_d   = wb_alu_q;
    squash     = flush_q | bus.flush;

    case (state_q)
      IDLE: begin
        if (bus.in_valid && !bus.flush) begin
          if (!is_mem || misaligned) begin
            wb_valid_d = 1'b1;
            addr_err_d = is_mem;
            wb_rw_d    = bus.RegWrite & ~is_mem;
            wb_rd_d    = bus.rd;
            wb_dtr_d   = bus.DatatoReg;
            wb_pc4_d   = bus.pc_4;
            wb_lui_d   = bus.lui_32;
            wb_alu_d   = bus.ALU_result;
            wb_mem_d   = '0;
          end else begin
            state_d = BUSY;
            cnt_d   = '0;
            flush_d = 1'b0;
            re_d    = bus.MemRead;
            we_d    = bus.MemWrite;
            uns_d   = bus.mem_unsigned;
            rw_d    = bus.RegWrite;
            size_d  = bus.mem_size;
            dtr_d   = bus.DatatoReg;
            rd_d    = bus.rd;
            pc4_d   = bus.pc_4;
            lui_d   = bus.lui_32;
            alu_d   = bus.ALU_result;
            wdata_d = in_wdata;
            be_d    = in_be;
          end
        end
      end
      BUSY: begin
        flush_d = squash;
        // Ack wins over timeout when both land on the same cycle.
        if (bus.dmem_ack || cnt_q == CNT_LAST) begin
          state_d    = IDLE;
          cnt_d      = '0;
          wb_valid_d = 1'b1;
          bus_err_d  = ~bus.dmem_ack;
          wb_rw_d    = rw_q & ~squash & bus.dmem_ack;
          wb_mem_d   = (re_q && bus.dmem_ack) ? load_data : '0;
          wb_rd_d    = rd_q;
          wb_dtr_d   = dtr_q;
          wb_pc4_d   = pc4_q;
          wb_lui_d   = lui_q;
          wb_alu_d   = alu_q;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      flush_q    <= 1'b0;
      re_q       <= 1'b0;
      we_q       <= 1'b0;
      uns_q      <= 1'b0;
      rw_q       <= 1'b0;
      size_q     <= '0;
      dtr_q      <= '0;
      rd_q       <= '0;
      pc4_q      <= '0;
      lui_q      <= '0;
      alu_q      <= '0;
      wdata_q    <= '0;
      be_q       <= '0;
      wb_valid_q <= 1'b0;
      wb_rw_q    <= 1'b0;
      wb_rd_q    <= '0;
      wb_dtr_q   <= '0;
      wb_pc4_q   <= '0;
      wb_lui_q   <= '0;
      wb_mem_q   <= '0;
      wb_alu_q   <= '0;
      addr_err_q <= 1'b0;
      bus_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      flush_q    <= flush_d;
      re_q       <= re_d;
      we_q       <= we_d;
      uns_q      <= uns_d;
      rw_q       <= rw_d;
      size_q     <= size_d;
      dtr_q      <= dtr_d;
      rd_q       <= rd_d;
      pc4_q      <= pc4_d;
      lui_q      <= lui_d;
      alu_q      <= alu_d;
      wdata_q    <= wdata_d;
      be_q       <= be_d;
      wb_valid_q <= wb_valid_d;
      wb_rw_q    <= wb_rw_d;
      wb_rd_q    <= wb_rd_d;
      wb_dtr_q   <= wb_dtr_d;
      wb_pc4_q   <= wb_pc4_d;
      wb_lui_q   <= wb_lui_d;
      wb_mem_q   <= wb_mem_d;
      wb_alu_q   <= wb_alu_d;
      addr_err_q <= addr_err_d;
      bus_err_q  <= bus_err_d;
    end
  end

  assign busy                = (state_q == BUSY);
  assign bus.in_ready        = (state_q == IDLE);
  assign bus.dmem_req        = busy;
  assign bus.dmem_we         = busy & we_q;
  assign bus.dmem_addr       = busy ? {alu_q[31:2], 2'b00} : '0;
  assign bus.dmem_be         = busy ? be_q : '0;
  assign bus.dmem_wdata      = busy ? wdata_q : '0;
  assign bus.wb_valid        = wb_valid_q;
  assign bus.wb_RegWrite     = wb_rw_q;
  assign bus.wb_rd           = wb_rd_q;
  assign bus.wb_DatatoReg    = wb_dtr_q;
  assign bus.wb_pc_4         = wb_pc4_q;
  assign bus.wb_lui_32       = wb_lui_q;
  assign bus.wb_mem_data_out = wb_mem_q;
  assign bus.wb_ALU_result   = wb_alu_q;
  assign bus.addr_err        = addr_err_q;
  assign bus.bus_err         = bus_err_q;

endmodule

// File: tb/tb_mem_access_stage.sv
// Self-checking bench for mem_access_stage: directed vector table, reset-mid-access
// sequence and randomized instructions checked against a behavioural model.
module tb_mem_access_stage;

  localparam int TIMEOUT = 16;

  logic clk;
  logic reset;
  int   n_chk;
  int   n_fail;

  mem_access_stage_if mif ();

  mem_access_stage #(.TIMEOUT(TIMEOUT), .CNT_W(5)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (mif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    bit          rd_en;
    bit          wr_en;
    bit [1:0]    size;
    bit          uns;
    bit          rw;
    bit [4:0]    rd;
    bit [1:0]    dtr;
    bit [31:0]   pc4;
    bit [31:0]   lui;
    bit [31:0]   alu;
    bit [31:0]   sd;
    bit [31:0]   rdata;
    int          ack_dly;
    int          flush_cyc;
    bit          flush_acc;
    int          exp_lat;
    int          exp_busy;
    bit [3:0]    exp_be;
    bit [31:0]   exp_wdata;
    bit [31:0]   exp_mem;
    bit          exp_rw;
    bit          exp_aerr;
    bit          exp_berr;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, got, exp);
    end
  endtask

  task automatic chk1(input string nm, input logic got, input logic exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b", nm, got, exp);
    end
  endtask

  function automatic vec_t mkv(input string nm, input bit r, input bit w, input bit [1:0] sz,
                               input bit uns, input bit rw, input bit [31:0] alu,
                               input bit [31:0] sd, input bit [31:0] rdata, input int ack,
                               input int flc, input bit fla, input int lat, input int busy,
                               input bit [3:0] be, input bit [31:0] wd, input bit [31:0] mem,
                               input bit erw, input bit ea, input bit eb);
    vec_t v;
    v.name = nm; v.rd_en = r; v.wr_en = w; v.size = sz; v.uns = uns; v.rw = rw;
    v.rd = '0; v.dtr = '0; v.pc4 = '0; v.lui = '0;
    v.alu = alu; v.sd = sd; v.rdata = rdata; v.ack_dly = ack; v.flush_cyc = flc;
    v.flush_acc = fla; v.exp_lat = lat; v.exp_busy = busy; v.exp_be = be;
    v.exp_wdata = wd; v.exp_mem = mem; v.exp_rw = erw; v.exp_aerr = ea; v.exp_berr = eb;
    return v;
  endfunction

  // Expected behaviour from the stage's rules, expressed arithmetically.
  function automatic vec_t model(input vec_t vi);
    vec_t        v;
    int unsigned a;
    int unsigned sh;
    int unsigned bits;
    logic [31:0] val;
    bit          mis;
    bit          squash;
    v = vi;
    a = 32'(v.alu[1:0]);
    mis = (v.size == 2'd1 && a % 2 == 1) || (v.size >= 2'd2 && a != 0);
    v.exp_lat = 0; v.exp_busy = 0; v.exp_rw = 0; v.exp_aerr = 0; v.exp_berr = 0;
    v.exp_mem = '0;
    case (v.size)
      2'd0: begin
        v.exp_be = 4'(1 << a);
        v.exp_wdata = 32'(v.sd[7:0]) * 32'h0101_0101;
      end
      2'd1: begin
        v.exp_be = (a >= 2) ? 4'hC : 4'h3;
        v.exp_wdata = 32'(v.sd[15:0]) * 32'h0001_0001;
      end
      default: begin
        v.exp_be = 4'hF;
        v.exp_wdata = v.sd;
      end
    endcase
    if (v.flush_acc) begin
      v.exp_lat = 0;
    end else if (!(v.rd_en || v.wr_en)) begin
      v.exp_lat = 1;
      v.exp_rw = v.rw;
    end else if (mis) begin
      v.exp_lat = 1;
      v.exp_aerr = 1;
    end else if (v.ack_dly >= 1 && v.ack_dly <= TIMEOUT) begin
      v.exp_busy = v.ack_dly;
      v.exp_lat = v.ack_dly + 1;
      squash = v.flush_cyc >= 1 && v.flush_cyc <= v.ack_dly;
      v.exp_rw = v.rw && !squash;
      if (v.rd_en) begin
        if (v.size >= 2'd2) begin
          val = v.rdata;
        end else begin
          bits = (v.size == 2'd0) ? 8 : 16;
          sh = (v.size == 2'd0) ? 8 * a : 16 * (a / 2);
          val = (v.rdata >> sh) & ((32'd1 << bits) - 32'd1);
          if (!v.uns && val >= (32'd1 << (bits - 1))) val = val - (32'd1 << bits);
        end
        v.exp_mem = val;
      end
    end else begin
      v.exp_busy = TIMEOUT;
      v.exp_lat = TIMEOUT + 1;
      v.exp_berr = 1;
    end
    return v;
  endfunction

  task automatic apply(input vec_t v);
    int lat;
    int reqc;
    int busyc;
    int limit;
    lat = 0; reqc = 0; busyc = 0;
    limit = (v.exp_lat == 0) ? 3 : TIMEOUT + 4;
    mif.in_valid = 1'b1;      mif.MemRead = v.rd_en;   mif.MemWrite = v.wr_en;
    mif.mem_size = v.size;    mif.mem_unsigned = v.uns; mif.RegWrite = v.rw;
    mif.rd = v.rd;            mif.DatatoReg = v.dtr;   mif.pc_4 = v.pc4;
    mif.lui_32 = v.lui;       mif.ALU_result = v.alu;  mif.store_data = v.sd;
    mif.flush = v.flush_acc;
    @(posedge clk); #1;
    mif.in_valid = 1'b0;
    mif.flush = 1'b0;
    for (int cyc = 1; cyc <= limit; cyc++) begin
      if (mif.wb_valid) begin
        lat = cyc;
        break;
      end
      if (mif.dmem_req) reqc++;
      if (!mif.in_ready) busyc++;
      if (cyc == 1 && v.exp_busy > 0) begin
        chk({v.name, ".addr"}, mif.dmem_addr, v.alu & 32'hFFFF_FFFC);
        chk({v.name, ".be"}, 32'(mif.dmem_be), 32'(v.exp_be));
        chk1({v.name, ".we"}, mif.dmem_we, v.wr_en);
        if (v.wr_en) chk({v.name, ".wdata"}, mif.dmem_wdata, v.exp_wdata);
      end
      mif.dmem_ack = (cyc == v.ack_dly);
      mif.dmem_rdata = v.rdata;
      mif.flush = (cyc == v.flush_cyc);
      @(posedge clk); #1;
      mif.dmem_ack = 1'b0;
      mif.flush = 1'b0;
    end
    chk({v.name, ".latency"}, lat, v.exp_lat);
    chk({v.name, ".req_cycles"}, reqc, v.exp_busy);
    chk({v.name, ".busy_cycles"}, busyc, v.exp_busy);
    if (lat != 0) begin
      chk1({v.name, ".in_ready"}, mif.in_ready, 1'b1);
      chk1({v.name, ".req_drop"}, mif.dmem_req, 1'b0);
      chk1({v.name, ".wb_RegWrite"}, mif.wb_RegWrite, v.exp_rw);
      chk1({v.name, ".addr_err"}, mif.addr_err, v.exp_aerr);
      chk1({v.name, ".bus_err"}, mif.bus_err, v.exp_berr);
      chk({v.name, ".wb_mem"}, mif.wb_mem_data_out, v.exp_mem);
      chk({v.name, ".wb_alu"}, mif.wb_ALU_result, v.alu);
      chk({v.name, ".wb_rd"}, 32'(mif.wb_rd), 32'(v.rd));
      chk({v.name, ".wb_dtr"}, 32'(mif.wb_DatatoReg), 32'(v.dtr));
      chk({v.name, ".wb_pc4"}, mif.wb_pc_4, v.pc4);
      chk({v.name, ".wb_lui"}, mif.wb_lui_32, v.lui);
      @(posedge clk); #1;
      chk1({v.name, ".wb_valid_pulse"}, mif.wb_valid, 1'b0);
      chk1({v.name, ".addr_err_pulse"}, mif.addr_err, 1'b0);
      chk1({v.name, ".bus_err_pulse"}, mif.bus_err, 1'b0);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t v;
    n_chk = 0;
    n_fail = 0;
    reset = 1'b1;
    mif.in_valid = 0; mif.flush = 0; mif.MemRead = 0; mif.MemWrite = 0; mif.mem_size = '0;
    mif.mem_unsigned = 0; mif.RegWrite = 0; mif.rd = '0; mif.DatatoReg = '0; mif.pc_4 = '0;
    mif.lui_32 = '0; mif.ALU_result = '0; mif.store_data = '0; mif.dmem_ack = 0;
    mif.dmem_rdata = '0;

    //           name             r  w  sz    u  rw alu          sd            rdata         ack fc fa lat bsy be    wdata         mem           rw ae be
    tbl.push_back(mkv("alu",       0, 0, 2'd0, 0, 1, 32'h1234,    32'h0,        32'h0,        0,  0, 0, 1,  0,  4'h0, 32'h0,        32'h0,        1, 0, 0));
    tbl.push_back(mkv("lb",        1, 0, 2'd0, 0, 1, 32'h103,     32'h0,        32'h80AABBCC, 3,  0, 0, 4,  3,  4'h8, 32'h0,        32'hFFFFFF80, 1, 0, 0));
    tbl.push_back(mkv("lbu",       1, 0, 2'd0, 1, 1, 32'h103,     32'h0,        32'h80AABBCC, 3,  0, 0, 4,  3,  4'h8, 32'h0,        32'h00000080, 1, 0, 0));
    tbl.push_back(mkv("sh",        0, 1, 2'd1, 0, 0, 32'h102,     32'h0000BEEF, 32'h0,        1,  0, 0, 2,  1,  4'hC, 32'hBEEFBEEF, 32'h0,        0, 0, 0));
    tbl.push_back(mkv("sb",        0, 1, 2'd0, 0, 0, 32'h101,     32'h12345678, 32'h0,        2,  0, 0, 3,  2,  4'h2, 32'h78787878, 32'h0,        0, 0, 0));
    tbl.push_back(mkv("lh",        1, 0, 2'd1, 0, 1, 32'h102,     32'h0,        32'h80017FFF, 1,  0, 0, 2,  1,  4'hC, 32'h0,        32'hFFFF8001, 1, 0, 0));
    tbl.push_back(mkv("lhu",       1, 0, 2'd1, 1, 1, 32'h100,     32'h0,        32'h8001F00D, 1,  0, 0, 2,  1,  4'h3, 32'h0,        32'h0000F00D, 1, 0, 0));
    tbl.push_back(mkv("lw_mis",    1, 0, 2'd2, 0, 1, 32'h101,     32'h0,        32'h0,        0,  0, 0, 1,  0,  4'h0, 32'h0,        32'h0,        0, 1, 0));
    tbl.push_back(mkv("lh_mis",    1, 0, 2'd1, 0, 1, 32'h103,     32'h0,        32'h0,        0,  0, 0, 1,  0,  4'h0, 32'h0,        32'h0,        0, 1, 0));
    tbl.push_back(mkv("lw_tmo",    1, 0, 2'd2, 0, 1, 32'h200,     32'h0,        32'h55555555, 0,  0, 0, 17, 16, 4'hF, 32'h0,        32'h0,        0, 0, 1));
    tbl.push_back(mkv("lw_acklast",1, 0, 2'd2, 0, 1, 32'h204,     32'h0,        32'hCAFEF00D, 16, 0, 0, 17, 16, 4'hF, 32'h0,        32'hCAFEF00D, 1, 0, 0));
    tbl.push_back(mkv("lw_flushb", 1, 0, 2'd2, 0, 1, 32'h208,     32'h0,        32'hDEADBEEF, 2,  1, 0, 3,  2,  4'hF, 32'h0,        32'hDEADBEEF, 0, 0, 0));
    tbl.push_back(mkv("lw_flusha", 1, 0, 2'd2, 0, 1, 32'h20C,     32'h0,        32'h0,        1,  0, 1, 0,  0,  4'hF, 32'h0,        32'h0,        0, 0, 0));
    tbl.push_back(mkv("lw_sz3",    1, 0, 2'd3, 0, 1, 32'h8,       32'h0,        32'h01234567, 1,  0, 0, 2,  1,  4'hF, 32'h0,        32'h01234567, 1, 0, 0));
    tbl.push_back(mkv("sw",        0, 1, 2'd2, 0, 0, 32'h10,      32'hA5A55A5A, 32'h0,        4,  0, 0, 5,  4,  4'hF, 32'hA5A55A5A, 32'h0,        0, 0, 0));
    tbl.push_back(mkv("alu_flush", 0, 0, 2'd0, 0, 1, 32'h77,      32'h0,        32'h0,        0,  0, 1, 0,  0,  4'h0, 32'h0,        32'h0,        0, 0, 0));

    repeat (2) @(posedge clk);
    #1;
    chk1("reset.in_ready", mif.in_ready, 1'b1);
    chk1("reset.dmem_req", mif.dmem_req, 1'b0);
    chk1("reset.wb_valid", mif.wb_valid, 1'b0);
    chk1("reset.addr_err", mif.addr_err, 1'b0);
    chk1("reset.bus_err", mif.bus_err, 1'b0);
    chk("reset.wb_alu", mif.wb_ALU_result, 32'h0);
    chk("reset.wb_mem", mif.wb_mem_data_out, 32'h0);
    chk("reset.dmem_be", 32'(mif.dmem_be), 32'h0);
    reset = 1'b0;

    foreach (tbl[i]) begin
      v = tbl[i];
      v.rd = 5'(5 + i);
      v.dtr = 2'(i);
      v.pc4 = 32'h0040_0000 + 32'(4 * i);
      v.lui = 32'(i) << 12;
      apply(v);
    end

    // Reset while a load is outstanding abandons it.
    mif.in_valid = 1'b1; mif.MemRead = 1'b1; mif.MemWrite = 1'b0; mif.mem_size = 2'd2;
    mif.ALU_result = 32'h300; mif.flush = 1'b0;
    @(posedge clk); #1;
    mif.in_valid = 1'b0;
    chk1("rst_busy.req_before", mif.dmem_req, 1'b1);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    chk1("rst_busy.req", mif.dmem_req, 1'b0);
    chk1("rst_busy.in_ready", mif.in_ready, 1'b1);
    chk1("rst_busy.wb_valid", mif.wb_valid, 1'b0);
    chk1("rst_busy.bus_err", mif.bus_err, 1'b0);
    reset = 1'b0;
    @(posedge clk); #1;
    chk1("rst_busy.req_after", mif.dmem_req, 1'b0);
    v = tbl[0];
    v.name = "alu_after_rst";
    v.rd = 5'd9; v.dtr = 2'd2; v.pc4 = 32'h0040_1000; v.lui = 32'hABCD_0000;
    apply(v);

    for (int i = 0; i < 40; i++) begin
      int op;
      op = int'($urandom_range(0, 3));
      v.name = $sformatf("rnd%0d", i);
      v.rd_en = (op == 1 || op == 3);
      v.wr_en = (op == 2);
      v.size = 2'($urandom_range(0, 3));
      v.uns = 1'($urandom_range(0, 1));
      v.rw = (op == 2) ? 1'b0 : 1'($urandom_range(0, 1));
      v.rd = 5'($urandom);
      v.dtr = 2'($urandom);
      v.pc4 = $urandom;
      v.lui = $urandom;
      v.alu = $urandom;
      v.sd = $urandom;
      v.rdata = $urandom;
      v.ack_dly = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, 5));
      v.flush_acc = ($urandom_range(0, 9) == 0);
      v.flush_cyc = ($urandom_range(0, 5) == 0) ? 1 : 0;
      v = model(v);
      apply(v);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
